uart_rx_cmd_parser: RTL and testbench

UART_RX_CMD_PARSER -- requirements
Module: uart_rx_cmd_parser

---
 rtl/uart_rx_cmd_parser.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_cmd_parser.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cmd_parser
//  Description : Frames SYNC/CMD/ADDR/DHI/DLO/CHK byte packets from a UART
//                receiver into a held command with checksum and timeout checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_parser #(
    parameter int unsigned TIMEOUT_CLKS = 50000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Cmd_Ack,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd,
    output logic [7:0]  o_Addr,
    output logic [15:0] o_Data,
    output logic        o_Chk_Err,
    output logic        o_Timeout,
    output logic        o_Overrun,
    output logic        o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DHI  = 3'd3,
        S_DLO  = 3'd4,
        S_CHK  = 3'd5
    } state_t;

    // Timeout fires on the edge where the idle counter would reach TIMEOUT_CLKS-1.
    localparam logic [15:0] c_TO_MATCH = 16'(TIMEOUT_CLKS - 2);

    state_t      state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [7:0]  xor_q,      xor_d;
    logic [7:0]  sh_cmd_q,   sh_cmd_d;
    logic [7:0]  sh_addr_q,  sh_addr_d;
    logic [15:0] sh_data_q,  sh_data_d;
    logic        valid_q,    valid_d;
    logic [7:0]  cmd_q,      cmd_d;
    logic [7:0]  addr_q,     addr_d;
    logic [15:0] data_q,     data_d;
    logic        chk_err_q,  chk_err_d;
    logic        timeout_q,  timeout_d;
    logic        overrun_q,  overrun_d;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            xor_q     <= '0;
            sh_cmd_q  <= '0;
            sh_addr_q <= '0;
            sh_data_q <= '0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            chk_err_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xor_q     <= xor_d;
            sh_cmd_q  <= sh_cmd_d;
            sh_addr_q <= sh_addr_d;
            sh_data_q <= sh_data_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_err_q <= chk_err_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        xor_d     = xor_q;
        sh_cmd_d  = sh_cmd_q;
        sh_addr_d = sh_addr_q;
        sh_data_d = sh_data_q;
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_err_d = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;

        if (valid_q && i_Cmd_Ack) begin
            valid_d = 1'b0;
        end

        if (state_q == S_IDLE || i_Rx_DV) begin
            cnt_d = '0;
        end

        if (i_Rx_DV) begin
            case (state_q)
                S_IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_d = S_CMD;
                        xor_d   = '0;
                    end
                end
                S_CMD: begin
                    sh_cmd_d = i_Rx_Byte;
                    xor_d    = xor_q ^ i_Rx_Byte;
                    state_d  = S_ADDR;
                end
                S_ADDR: begin
                    sh_addr_d = i_Rx_Byte;
                    xor_d     = xor_q ^ i_Rx_Byte;
                    state_d   = S_DHI;
                end
                S_DHI: begin
                    sh_data_d[15:8] = i_Rx_Byte;
                    xor_d           = xor_q ^ i_Rx_Byte;
                    state_d         = S_DLO;
                end
                S_DLO: begin
                    sh_data_d[7:0] = i_Rx_Byte;
                    xor_d          = xor_q ^ i_Rx_Byte;
                    state_d        = S_CHK;
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (i_Rx_Byte == xor_q) begin
                        // A same-cycle ack frees the slot for the new frame.
                        if (!valid_q || i_Cmd_Ack) begin
                            valid_d = 1'b1;
                            cmd_d   = sh_cmd_q;
                            addr_d  = sh_addr_q;
                            data_d  = sh_data_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && cnt_q == c_TO_MATCH) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end
    end

    assign o_Cmd_Valid = valid_q;
    assign o_Cmd       = cmd_q;
    assign o_Addr      = addr_q;
    assign o_Data      = data_q;
    assign o_Chk_Err   = chk_err_q;
    assign o_Timeout   = timeout_q;
    assign o_Overrun   = overrun_q;
    assign o_Busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cmd_parser
//  Description : Directed frame table, corner sequences and randomized byte
//                stream against a queue-based frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd_parser;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rxb;
    logic        ack;
    logic        o_Cmd_Valid;
    logic [7:0]  o_Cmd;
    logic [7:0]  o_Addr;
    logic [15:0] o_Data;
    logic        o_Chk_Err;
    logic        o_Timeout;
    logic        o_Overrun;
    logic        o_Busy;

    uart_rx_cmd_parser #(
        .TIMEOUT_CLKS (TO),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_Rx_DV     (dv),
        .i_Rx_Byte   (rxb),
        .i_Cmd_Ack   (ack),
        .o_Cmd_Valid (o_Cmd_Valid),
        .o_Cmd       (o_Cmd),
        .o_Addr      (o_Addr),
        .o_Data      (o_Data),
        .o_Chk_Err   (o_Chk_Err),
        .o_Timeout   (o_Timeout),
        .o_Overrun   (o_Overrun),
        .o_Busy      (o_Busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_chk = 0;
    int n_to  = 0;
    int n_ovr = 0;

    always @(negedge clk) begin
        if (o_Chk_Err) n_chk <= n_chk + 1;
        if (o_Timeout) n_to  <= n_to + 1;
        if (o_Overrun) n_ovr <= n_ovr + 1;
    end

    typedef struct {
        logic [47:0] frame;
        logic        ack_chk;
        logic        exp_valid;
        logic [7:0]  exp_cmd;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        int          exp_chk;
        int          exp_ovr;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; the byte is sampled on the next edge.
    task automatic strobe(input logic [7:0] b, input logic a);
        dv  = 1'b1;
        rxb = b;
        ack = a;
        @(posedge clk);
        #1;
        dv  = 1'b0;
        ack = 1'b0;
        rxb = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [47:0] f, input logic ack_chk);
        for (int i = 0; i < 6; i++) begin
            strobe(f[47-8*i -: 8], (i == 5) ? ack_chk : 1'b0);
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic chk_cmd(input string name, input logic [7:0] c, input logic [7:0] a, input logic [15:0] d);
        chk({name, "_valid"}, o_Cmd_Valid, 1);
        chk({name, "_cmd"},   o_Cmd, c);
        chk({name, "_addr"},  o_Addr, a);
        chk({name, "_data"},  o_Data, d);
    endtask

    initial begin
        int c0, o0, t0;
        int g;
        int r;
        int nkeep;
        logic        a;
        logic [7:0]  b;
        logic [7:0]  x;
        logic [7:0]  p[4];
        logic [7:0]  fb[$];
        // reference model state
        logic        m_in;
        logic [7:0]  m_q[$];
        logic        m_pend;
        logic [7:0]  m_cmd, m_addr;
        logic [15:0] m_data;
        logic        m_loaded;
        int          m_chk, m_ovr, m_to;

        tbl[0] = '{48'hA5_01_10_12_34_37, 1'b0, 1'b1, 8'h01, 8'h10, 16'h1234, 0, 0};
        tbl[1] = '{48'hA5_01_10_12_34_38, 1'b0, 1'b1, 8'h01, 8'h10, 16'h1234, 1, 0};
        tbl[2] = '{48'hA5_02_20_00_01_23, 1'b0, 1'b1, 8'h01, 8'h10, 16'h1234, 0, 1};
        tbl[3] = '{48'hA5_02_20_00_01_23, 1'b1, 1'b1, 8'h02, 8'h20, 16'h0001, 0, 0};
        tbl[4] = '{48'hA5_FF_A5_A5_A5_5A, 1'b1, 1'b1, 8'hFF, 8'hA5, 16'hA5A5, 0, 0};

        rst = 1'b1;
        dv  = 1'b0;
        ack = 1'b0;
        rxb = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_Cmd_Valid, 0);
        chk("rst_outs", {o_Cmd, o_Addr, o_Data}, 0);
        chk("rst_pulses", {o_Chk_Err, o_Timeout, o_Overrun, o_Busy}, 0);
        rst = 1'b0;
        idle(2);

        // Bad checksum with nothing pending
        c0 = n_chk;
        send_frame(48'hA5_01_10_12_34_38, 1'b0);
        chk("badchk_pulse", o_Chk_Err, 1);
        idle(1);
        chk("badchk_single", o_Chk_Err, 0);
        chk("badchk_valid", o_Cmd_Valid, 0);
        chk("badchk_count", n_chk - c0, 1);

        foreach (tbl[i]) begin
            c0 = n_chk;
            o0 = n_ovr;
            send_frame(tbl[i].frame, tbl[i].ack_chk);
            chk($sformatf("tbl%0d_valid", i), o_Cmd_Valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_cmd", i), o_Cmd, tbl[i].exp_cmd);
            chk($sformatf("tbl%0d_addr", i), o_Addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_data", i), o_Data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), o_Busy, 0);
            idle(1);
            chk($sformatf("tbl%0d_chkerr", i), n_chk - c0, tbl[i].exp_chk);
            chk($sformatf("tbl%0d_ovr", i), n_ovr - o0, tbl[i].exp_ovr);
        end

        ack_pulse();
        chk("ack_clear", o_Cmd_Valid, 0);
        ack_pulse();
        chk("ack_idle_valid", o_Cmd_Valid, 0);
        chk("ack_idle_cmd", o_Cmd, 8'hFF);

        // Garbage before SYNC
        strobe(8'h00, 1'b0);
        chk("garb0_busy", o_Busy, 0);
        strobe(8'hFF, 1'b0);
        chk("garbFF_busy", o_Busy, 0);
        send_frame(48'hA5_02_20_00_01_23, 1'b0);
        chk_cmd("garb_frame", 8'h02, 8'h20, 16'h0001);
        idle(20);
        chk_cmd("garb_hold", 8'h02, 8'h20, 16'h0001);
        ack_pulse();

        // Timeout exactly TO-1 cycles after the last strobe
        t0 = n_to;
        strobe(8'hA5, 1'b0);
        strobe(8'h01, 1'b0);
        idle(TO - 2);
        chk("to_early", o_Timeout, 0);
        chk("to_early_busy", o_Busy, 1);
        idle(1);
        chk("to_pulse", o_Timeout, 1);
        chk("to_busy", o_Busy, 0);
        idle(1);
        chk("to_single", o_Timeout, 0);
        chk("to_count", n_to - t0, 1);
        send_frame(48'hA5_04_40_56_78_6A, 1'b0);
        chk_cmd("to_next", 8'h04, 8'h40, 16'h5678);
        ack_pulse();

        // Byte arriving on the timeout cycle wins
        t0 = n_to;
        strobe(8'hA5, 1'b0);
        strobe(8'h01, 1'b0);
        idle(TO - 2);
        strobe(8'h10, 1'b0);
        chk("prio_busy", o_Busy, 1);
        chk("prio_to", o_Timeout, 0);
        strobe(8'h12, 1'b0);
        strobe(8'h34, 1'b0);
        strobe(8'h37, 1'b0);
        chk_cmd("prio_frame", 8'h01, 8'h10, 16'h1234);
        idle(1);
        chk("prio_to_count", n_to - t0, 0);

        // Asynchronous reset mid-frame with a command pending
        strobe(8'hA5, 1'b0);
        strobe(8'h01, 1'b0);
        strobe(8'h10, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", o_Cmd_Valid, 0);
        chk("arst_outs", {o_Cmd, o_Addr, o_Data}, 0);
        chk("arst_busy", o_Busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = n_chk;
        strobe(8'h10, 1'b0);
        strobe(8'h12, 1'b0);
        strobe(8'h34, 1'b0);
        strobe(8'h37, 1'b0);
        idle(1);
        chk("arst_nocmd", o_Cmd_Valid, 0);
        chk("arst_nobusy", o_Busy, 0);
        chk("arst_nochk", n_chk - c0, 0);

        // Randomized stream against the frame model
        m_in = 1'b0;
        m_q.delete();
        m_pend = 1'b0;
        m_cmd = '0;
        m_addr = '0;
        m_data = '0;
        m_chk = 0;
        m_ovr = 0;
        m_to = 0;
        c0 = n_chk;
        o0 = n_ovr;
        t0 = n_to;
        for (int it = 0; it < 150; it++) begin
            fb.delete();
            r = $urandom_range(0, 9);
            if (r < 2) begin
                fb.push_back(8'($urandom));
            end else begin
                x = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    p[k] = 8'($urandom);
                    x = x ^ p[k];
                end
                fb.push_back(8'hA5);
                for (int k = 0; k < 4; k++) fb.push_back(p[k]);
                if (r == 2) fb.push_back(x ^ 8'($urandom_range(1, 255)));
                else        fb.push_back(x);
                if (r == 3) begin
                    nkeep = $urandom_range(1, 5);
                    while (fb.size() > nkeep) void'(fb.pop_back());
                end
            end
            for (int k = 0; k < fb.size(); k++) begin
                g = $urandom_range(0, 3);
                if ($urandom_range(0, 24) == 0) g = $urandom_range(TO - 2, TO + 20);
                b = fb[k];
                a = ($urandom_range(0, 3) == 0);
                if (m_in && g >= TO - 1) begin
                    m_to++;
                    m_in = 1'b0;
                end
                m_loaded = 1'b0;
                if (!m_in) begin
                    if (b == 8'hA5) begin
                        m_in = 1'b1;
                        m_q.delete();
                    end
                end else if (m_q.size() < 4) begin
                    m_q.push_back(b);
                end else begin
                    m_in = 1'b0;
                    if (b == (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) begin
                        if (!m_pend || a) begin
                            m_pend = 1'b1;
                            m_loaded = 1'b1;
                            m_cmd = m_q[0];
                            m_addr = m_q[1];
                            m_data = {m_q[2], m_q[3]};
                        end else begin
                            m_ovr++;
                        end
                    end else begin
                        m_chk++;
                    end
                end
                if (a && !m_loaded) m_pend = 1'b0;
                idle(g);
                strobe(b, a);
                chk("rnd_valid", o_Cmd_Valid, m_pend);
                chk("rnd_busy", o_Busy, m_in);
                if (m_pend) begin
                    chk("rnd_cmd", o_Cmd, m_cmd);
                    chk("rnd_addr", o_Addr, m_addr);
                    chk("rnd_data", o_Data, m_data);
                end
            end
        end
        idle(TO + 5);
        if (m_in) begin
            m_to++;
            m_in = 1'b0;
        end
        chk("rnd_end_busy", o_Busy, 0);
        chk("rnd_chk_count", n_chk - c0, m_chk);
        chk("rnd_ovr_count", n_ovr - o0, m_ovr);
        chk("rnd_to_count", n_to - t0, m_to);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
